// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field widths, special encodings
// and the iterative-unit FSM state type.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] FP_NAN  = 32'h7F80_0001;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even increment on a normalised mantissa. The fsqrt unit
// uses this same equation; carry_o flags a mantissa overflow into the exponent.
module fpu_round_rne
  import fpu_pkg::*;
(
  input  logic [MAN_W-1:0] man_i,
  input  logic             ulp_i,
  input  logic             guard_i,
  input  logic             round_i,
  input  logic             sticky_i,
  output logic [MAN_W-1:0] man_o,
  output logic             carry_o
);

  logic inc_s;

  assign inc_s            = guard_i & (round_i | sticky_i | ulp_i);
  assign {carry_o, man_o} = {1'b0, man_i} + {{MAN_W{1'b0}}, inc_s};

endmodule

// File: rtl/fsquare_iter.sv
// Iterative single-precision squarer d = s*s with a radix-2^RADIX_BITS
// shift-add mantissa multiplier. Define FSQUARE_FLAGS_EN to add the flags port.
module fsquare_iter
  import fpu_pkg::*;
#(
  parameter int RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] s,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d
`ifdef FSQUARE_FLAGS_EN
  ,
  output logic [2:0]  flags
`endif
);

  localparam logic [4:0] CNT_INIT = 5'(24 / RADIX_BITS - 1);

  fsm_state_t        state_q, state_d;
  logic [47:0]       acc_q, acc_d;
  logic [47:0]       mcand_q, mcand_d;
  logic [23:0]       mult_q, mult_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [31:0]       d_q, d_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
`ifdef FSQUARE_FLAGS_EN
  logic [2:0]        flags_q, flags_d;
`endif

  logic [47:0]       partial_s;
  logic              ne_s;
  logic [MAN_W-1:0]  man_s, rnd_man_s;
  logic              ulp_s, guard_s, round_s, sticky_s, rnd_carry_s;
  logic signed [9:0] e_s;
  logic              unused_sign_s;

  assign unused_sign_s = s[31];
  assign partial_s     = mcand_q * {{(48-RADIX_BITS){1'b0}}, mult_q[RADIX_BITS-1:0]};

  // Normalisation field selection from the finished product.
  always_comb begin
    ne_s = acc_q[47];
    if (acc_q[47]) begin
      man_s    = acc_q[46:24];
      ulp_s    = acc_q[24];
      guard_s  = acc_q[23];
      round_s  = acc_q[22];
      sticky_s = |acc_q[21:0];
    end else begin
      man_s    = acc_q[45:23];
      ulp_s    = acc_q[23];
      guard_s  = acc_q[22];
      round_s  = acc_q[21];
      sticky_s = |acc_q[20:0];
    end
  end

  fpu_round_rne u_round (
    .man_i    (man_s),
    .ulp_i    (ulp_s),
    .guard_i  (guard_s),
    .round_i  (round_s),
    .sticky_i (sticky_s),
    .man_o    (rnd_man_s),
    .carry_o  (rnd_carry_s)
  );

  // A rounding carry leaves an all-zero mantissa, so only e needs the bump.
  assign e_s = $signed({1'b0, exp_q, 1'b0}) - 10'sd127
             + $signed({9'd0, ne_s}) + $signed({9'd0, rnd_carry_s});

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mult_d      = mult_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    d_d         = d_q;
    out_valid_d = out_valid_q;
`ifdef FSQUARE_FLAGS_EN
    flags_d     = flags_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          exp_d = s[30:23];
          if (s[30:23] == 8'd0) begin
            d_d     = FP_ZERO;
`ifdef FSQUARE_FLAGS_EN
            flags_d = 3'b000;
`endif
            state_d = DONE;
          end else if (s[30:23] == 8'hFF) begin
            d_d     = (s[22:0] != 23'd0) ? FP_NAN : FP_PINF;
`ifdef FSQUARE_FLAGS_EN
            flags_d = (s[22:0] != 23'd0) ? 3'b100 : 3'b010;
`endif
            state_d = DONE;
          end else begin
            mcand_d = {24'd0, 1'b1, s[22:0]};
            mult_d  = {1'b1, s[22:0]};
            acc_d   = 48'd0;
            cnt_d   = CNT_INIT;
            state_d = MUL;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        acc_d   = acc_q + partial_s;
        mcand_d = mcand_q << RADIX_BITS;
        mult_d  = mult_q >> RADIX_BITS;
        if (cnt_q == 5'd0) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      NORM: begin
        if (e_s >= 10'sd255) begin
          d_d = FP_PINF;
`ifdef FSQUARE_FLAGS_EN
          flags_d = 3'b010;
`endif
        end else if (e_s <= 10'sd0) begin
          d_d = FP_ZERO;
`ifdef FSQUARE_FLAGS_EN
          flags_d = 3'b001;
`endif
        end else begin
          d_d = {1'b0, e_s[7:0], rnd_man_s};
`ifdef FSQUARE_FLAGS_EN
          flags_d = 3'b000;
`endif
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        // Specials arrive here with out_valid low; it rises one cycle later.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      acc_q       <= 48'd0;
      mcand_q     <= 48'd0;
      mult_q      <= 24'd0;
      cnt_q       <= 5'd0;
      exp_q       <= 8'd0;
      d_q         <= 32'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef FSQUARE_FLAGS_EN
      flags_q     <= 3'b000;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mult_q      <= mult_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef FSQUARE_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  assign d         = d_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
`ifdef FSQUARE_FLAGS_EN
  assign flags     = flags_q;
`endif

endmodule

// File: doc/fsquare_iter.md
Name: fsquare_iter

Overview:
- Iterative IEEE-754 single-precision squarer, d = s*s, with ready/valid handshakes on input and output.
- Inverse operation of the FPU's fsqrt: sits beside it in the FPU and serves the core's squaring ops.
- Also serves the fsqrt round-trip self-check: sqrt(x)^2 is compared against x within 1 ulp.
- Uses a shift-add mantissa multiplier that retires RADIX_BITS multiplier bits per cycle, which trades latency for area.

Parameters:
- RADIX_BITS, 1: multiplier bits consumed per MUL cycle. Legal values are 1, 2, 3, 4, 6, 8 (must divide 24).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operand s is valid
- in_ready  out  1  block can accept an operand
- s  in  32  operand (sign, exp[7:0], mantissa[22:0])
- out_valid  out  1  result d is valid
- out_ready  in  1  consumer accepts d
- d  out  32  result

Behaviour:
- Interface (already decided): one clock, clk. Reset rstn is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, d=0. Internal accumulators clear to 0.
- Deasserting rstn mid-operation aborts the operation. No result is ever emitted for the aborted operand.
- FSM states: IDLE, MUL, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch s. Special cases go to DONE with d already formed; all other operands go to MUL.
  - Special cases:
    - exp==0 (zero/denormal, flushed): d=32'h00000000.
    - exp==255 with mantissa!=0: d=32'h7F800001 (codebase NaN).
    - exp==255 with mantissa==0: d=32'h7F800000.
- MUL:
  - Datapath: m={1,mant} (24 b), 48-bit accumulator, counter from 24/RADIX_BITS-1 down to 0.
  - Each cycle: acc += m * (next RADIX_BITS LSBs of multiplier) << position, then shift the multiplier.
  - Counter==0 goes to NORM.
- NORM (1 cycle):
  - Normalise:
    - If acc[47]=1: ne=1, mantissa=acc[46:24], ulp=acc[24], guard=acc[23], round=acc[22], sticky=|acc[21:0].
    - Otherwise: ne=0, all fields taken one bit lower.
  - Exponent: 10-bit signed e = 2*exp - 127 + ne.
  - Rounding is round-to-nearest-even: increment when guard && (round || sticky || ulp).
  - A mantissa carry-out from rounding zeroes the mantissa and increments e.
  - e>=255 gives d=32'h7F800000. e<=0 gives d=0 (no denormals).
  - Otherwise d={1'b0, e[7:0], mantissa}.
  - Go to DONE.
- DONE:
  - out_valid=1. d is held stable until out_ready is sampled high.
  - On that edge: out_valid drops to 0 and the state returns to IDLE.
  - No bypass: the next operand is accepted in IDLE, at the earliest 1 cycle after the output handshake.
- Result sign is always 0.
- Latency from the input-accept edge to out_valid high:
  - Normal operand: 24/RADIX_BITS + 1 cycles (25 for RADIX_BITS=1).
  - Special operand: 1 cycle.
- Throughput: at most one operation in flight. in_ready=0 in every state except IDLE.

Optional Feature:
- Macro FSQUARE_FLAGS_EN.
- Defined: adds output port flags[2:0] = {invalid, overflow, underflow}.
  - Registered alongside d and valid with out_valid.
  - invalid is set for a NaN input.
  - overflow is set for e>=255 or an inf input.
  - underflow is set for e<=0 with a nonzero input.
- Undefined: no port and no logic; d is identical in both builds.

Decomposition:
- Package fpu_pkg holds:
  - field widths: EXP_W=8, MAN_W=23
  - BIAS=127
  - constants FP_NAN=32'h7F800001, FP_PINF=32'h7F800000, FP_ZERO
  - FSM state enum
- Sub-module fpu_round_rne: combinational ulp/guard/round/sticky increment and carry-out. It is shared with fsqrt, and the fsqrt rounding equation is preserved exactly.

Test Plan:
- s=32'h40400000 (3.0), RADIX_BITS=1 -> d=32'h41100000 (9.0); out_valid exactly 25 cycles after the accept edge; in_ready=0 throughout.
- s=32'hC0000000 (-2.0) -> 32'h40800000. s=32'h3F800001 -> 32'h3F800002 (discarded tail is only the 2^-46 sticky bit; guard=0, so no increment).
- s=32'h60AD78EC (~1e20) -> 32'h7F800000, flags=3'b010. s=32'h0DA24260 (~1e-30) -> 0, flags=3'b001. s=32'h7FC00000 -> 32'h7F800001, out_valid 1 cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> d and out_valid stable and in_ready=0; release -> out_valid falls; the next operand is accepted 1 cycle later.
- Pulse rstn low mid-MUL on 3.0, then apply 1.5 (32'h3FC00000) -> only 32'h40100000 emitted; repeat the first 4 cases with RADIX_BITS=4 -> latency 7, identical d.
